// File: rtl/antifurto_pkg.sv
// Shared definitions for the anti-theft controller: interval codes, default
// delays and the timer state encoding.
package antifurto_pkg;

  typedef enum logic [1:0] {
    INT_ARM    = 2'b00,
    INT_DRIVER = 2'b01,
    INT_PASS   = 2'b10,
    INT_ALARM  = 2'b11
  } interval_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } timer_state_e;

  localparam int DEFAULT_ARM_S    = 6;
  localparam int DEFAULT_DRIVER_S = 8;
  localparam int DEFAULT_PASS_S   = 15;
  localparam int DEFAULT_ALARM_S  = 10;

  // A zero-second delay would make the countdown meaningless, so it becomes 1 s.
  function automatic logic [3:0] clamp_delay(input logic [3:0] value);
    return (value == 4'd0) ? 4'd1 : value;
  endfunction

endpackage

// File: rtl/one_hz_divider.sv
// Prescaler producing a one-cycle strobe every CLK_FREQ cycles, with a
// synchronous clear so a fresh countdown always starts on a full second.
module one_hz_divider #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic strobe
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] TERMINAL = PW'(CLK_FREQ - 1);

  logic [PW-1:0] prescaler;

  // tick is the edge on which the registered strobe rises; the countdown
  // consumes it directly so count and strobe change together.
  assign tick = (prescaler == TERMINAL) && !clear;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      strobe    <= 1'b0;
    end else if (clear) begin
      prescaler <= '0;
      strobe    <= 1'b0;
    end else begin
      strobe    <= tick;
      prescaler <= (prescaler == TERMINAL) ? '0 : prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/timer_antifurto.sv
// Seconds countdown for the anti-theft FSM: four reprogrammable delay slots,
// a 1 Hz prescaler and an IDLE/RUN/DONE countdown with a level expired flag.
module timer_antifurto
  import antifurto_pkg::*;
#(
  parameter int CLK_FREQ         = 50000000,
  parameter int T_ARM_DEFAULT    = DEFAULT_ARM_S,
  parameter int T_DRIVER_DEFAULT = DEFAULT_DRIVER_S,
  parameter int T_PASS_DEFAULT   = DEFAULT_PASS_S,
  parameter int T_ALARM_DEFAULT  = DEFAULT_ALARM_S
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       one_hz_enable,
  output logic [3:0] count_value
);

  timer_state_e state;
  logic [3:0]   slot [4];
  logic         tick;

  one_hz_divider #(
    .CLK_FREQ(CLK_FREQ)
  ) u_divider (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_timer),
    .tick   (tick),
    .strobe (one_hz_enable)
  );

  // NOTE: the delay slots are a tiny register file, not a RAM, so they take
  // an asynchronous reset to restore the factory delays.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot[INT_ARM]    <= 4'(T_ARM_DEFAULT);
      slot[INT_DRIVER] <= 4'(T_DRIVER_DEFAULT);
      slot[INT_PASS]   <= 4'(T_PASS_DEFAULT);
      slot[INT_ALARM]  <= 4'(T_ALARM_DEFAULT);
    end else if (reprogram) begin
      slot[time_param_sel] <= clamp_delay(time_value);
    end
  end

  // A start in the same cycle as a slot write loads the old slot value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count_value <= 4'd0;
      expired     <= 1'b0;
    end else if (start_timer) begin
      state       <= RUN;
      count_value <= slot[interval];
      expired     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (tick) begin
            if (count_value <= 4'd1) begin
              count_value <= 4'd0;
              expired     <= 1'b1;
              state       <= DONE;
            end else begin
              count_value <= count_value - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_antifurto.sv
// Self-checking bench for timer_antifurto (CLK_FREQ=4): directed scenarios
// plus random traffic against a seconds-elapsed reference model.
module tb_timer_antifurto;

  localparam int CF = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_timer = 1'b0;
  logic [1:0] interval = 2'b00;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_sel = 2'b00;
  logic [3:0] time_value = 4'd0;
  logic       expired;
  logic       one_hz_enable;
  logic [3:0] count_value;

  int checks = 0;
  int errors = 0;

  // Reference model: delay table, value of the last load, clock edges since
  // the last load (or reset), and whether anything has been loaded yet.
  int m_slot [4];
  int m_load;
  int m_elapsed;
  bit m_loaded;

  timer_antifurto #(.CLK_FREQ(CF)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_timer    (start_timer),
    .interval       (interval),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .count_value    (count_value)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot[0] = 6;
    m_slot[1] = 8;
    m_slot[2] = 15;
    m_slot[3] = 10;
    m_load = 0;
    m_elapsed = 0;
    m_loaded = 1'b0;
  endtask

  function automatic int exp_count();
    int rem;
    rem = m_load - m_elapsed / CF;
    if (!m_loaded || rem <= 0) return 0;
    return rem;
  endfunction

  function automatic bit exp_expired();
    return m_loaded && (m_load - m_elapsed / CF <= 0);
  endfunction

  function automatic bit exp_strobe();
    return (m_elapsed > 0) && (m_elapsed % CF == 0);
  endfunction

  // One clock: drive at the falling edge, advance the model, check after the rising edge.
  task automatic step(input logic st, input logic [1:0] iv, input logic rp,
                      input logic [1:0] sel, input logic [3:0] tv);
    @(negedge clock);
    start_timer = st;
    interval = iv;
    reprogram = rp;
    time_param_sel = sel;
    time_value = tv;
    @(posedge clock);
    #1;
    if (st) begin
      m_load = m_slot[iv];
      m_elapsed = 0;
      m_loaded = 1'b1;
    end else begin
      m_elapsed++;
    end
    if (rp) m_slot[sel] = (tv == 0) ? 1 : int'(tv);
    check("count_value", 8'(count_value), 8'(exp_count()));
    check("expired", 8'(expired), 8'(exp_expired()));
    check("one_hz_enable", 8'(one_hz_enable), 8'(exp_strobe()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
  endtask

  // Counts idle cycles until expired rises; a blown budget is a failed check.
  task automatic wait_expired(input string tag, input int want);
    int n;
    n = 0;
    while (expired !== 1'b1 && n < 200) begin
      step(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
      n++;
    end
    check(tag, 8'(n), 8'(want));
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_count", 8'(count_value), 8'd0);
    check("reset_expired", 8'(expired), 8'd0);
    check("reset_strobe", 8'(one_hz_enable), 8'd0);
    @(posedge clock);
    #2 reset = 1'b1;

    // Driver-door delay: 8 s = 32 cycles, then expired holds.
    step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    check("load_driver", 8'(count_value), 8'd8);
    wait_expired("latency_driver", 32);
    idle(20);
    check("expired_hold", 8'(expired), 8'd1);

    // Reprogram passenger slot to 3, then to 0 (clamped to 1).
    step(1'b0, 2'b00, 1'b1, 2'b10, 4'd3);
    step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    check("restart_from_done", 8'(expired), 8'd0);
    wait_expired("latency_pass3", 12);
    step(1'b0, 2'b00, 1'b1, 2'b10, 4'd0);
    step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    check("load_clamped", 8'(count_value), 8'd1);
    wait_expired("latency_pass1", 4);

    // Restart mid-countdown with a different interval.
    step(1'b1, 2'b11, 1'b0, 2'b00, 4'd0);
    idle(3 * CF);
    check("alarm_after_3s", 8'(count_value), 8'd7);
    step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    check("reload_arm", 8'(count_value), 8'd6);
    wait_expired("latency_arm", 24);

    // Start and reprogram of the selected slot in one cycle.
    step(1'b1, 2'b00, 1'b1, 2'b00, 4'd2);
    check("load_prewrite", 8'(count_value), 8'd6);
    idle(5);
    step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    check("load_postwrite", 8'(count_value), 8'd2);

    // Start held high: no progress, expired stays low.
    for (int i = 0; i < 6; i++) step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    idle(2);

    // Asynchronous reset mid-count with a reprogrammed driver slot.
    step(1'b0, 2'b00, 1'b1, 2'b01, 4'd13);
    step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    idle(3 * CF);
    check("before_reset", 8'(count_value), 8'd10);
    #2 reset = 1'b0;
    #1;
    check("async_count", 8'(count_value), 8'd0);
    check("async_expired", 8'(expired), 8'd0);
    check("async_strobe", 8'(one_hz_enable), 8'd0);
    model_reset();
    start_timer = 1'b0;
    reprogram = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    check("default_restored", 8'(count_value), 8'd8);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 30) == 0, 2'($urandom), ($urandom % 15) == 0,
           2'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
